// File: rtl/alu_reservation_station_pkg.sv
// Shared types for the ALU reservation station: entry layout, ALU op enum,
// ROB bus / completion payload and the funct3/funct7 decode helper.
package rv32i_types;

  localparam int WIDTH    = 32;
  localparam int ROB_SIZE = 8;
  localparam int RS_SIZE  = 8;
  localparam int TAG_W    = 4;

  localparam logic [6:0] op_reg   = 7'b0110011;
  localparam logic [6:0] op_imm   = 7'b0010011;
  localparam logic [6:0] op_auipc = 7'b0010111;

  localparam logic [2:0] f3_add  = 3'b000;
  localparam logic [2:0] f3_sll  = 3'b001;
  localparam logic [2:0] f3_slt  = 3'b010;
  localparam logic [2:0] f3_sltu = 3'b011;
  localparam logic [2:0] f3_xor  = 3'b100;
  localparam logic [2:0] f3_sr   = 3'b101;
  localparam logic [2:0] f3_or   = 3'b110;
  localparam logic [2:0] f3_and  = 3'b111;
  // funct7 bit that selects sub (reg form only) and sra/srai
  localparam int f7_alt_bit = 5;

  typedef enum logic [3:0] {
    alu_add, alu_sub, alu_sll, alu_slt, alu_sltu,
    alu_xor, alu_srl, alu_sra, alu_or, alu_and
  } alu_ops;

  typedef struct packed {
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] pc;
  } pci_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             rdy;
    logic [WIDTH-1:0] data;
  } sal_t;

  typedef struct packed {
    logic             busy;
    logic [TAG_W-1:0] tag;
    alu_ops           op;
    logic             use_imm;
    logic             use_pc;
    logic [TAG_W-1:0] q1;
    logic [TAG_W-1:0] q2;
    logic             r1;
    logic             r2;
    logic [WIDTH-1:0] v1;
    logic [WIDTH-1:0] v2;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] pc;
  } rs_entry_t;

  // auipc is an add of pc+imm; sub only exists in the register form,
  // while sra/srai share the alternate funct7 bit.
  function automatic alu_ops decode_op(input pci_t p);
    alu_ops o;
    o = alu_add;
    if (p.opcode != op_auipc) begin
      case (p.funct3)
        f3_add:  o = (p.opcode == op_reg && p.funct7[f7_alt_bit]) ? alu_sub : alu_add;
        f3_sll:  o = alu_sll;
        f3_slt:  o = alu_slt;
        f3_sltu: o = alu_sltu;
        f3_xor:  o = alu_xor;
        f3_sr:   o = p.funct7[f7_alt_bit] ? alu_sra : alu_srl;
        f3_or:   o = alu_or;
        default: o = alu_and;
      endcase
    end
    return o;
  endfunction

endpackage

// File: rtl/alu_reservation_station_alu.sv
// Combinational integer ALU used by the reservation station issue port.
module rs_alu_unit
  import rv32i_types::*;
#(
  parameter int width = WIDTH
) (
  input  alu_ops           op,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic [width-1:0] result
);

  localparam int SH_W = $clog2(width);

  logic [SH_W-1:0] sh;
  assign sh = b[SH_W-1:0];

  // Result select; compares are zero-extended single bits
  always_comb begin
    result = '0;
    case (op)
      alu_add:  result = a + b;
      alu_sub:  result = a - b;
      alu_sll:  result = a << sh;
      alu_slt:  result = {{(width-1){1'b0}}, $signed(a) < $signed(b)};
      alu_sltu: result = {{(width-1){1'b0}}, a < b};
      alu_xor:  result = a ^ b;
      alu_srl:  result = a >> sh;
      alu_sra:  result = $signed(a) >>> sh;
      alu_or:   result = a | b;
      alu_and:  result = a & b;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation station: buffers dispatched ALU ops until both operands are
// known (from dispatch or by snooping the ROB bus), issues the lowest-index
// ready entry each cycle and pulses its result back to the ROB.
module alu_reservation_station
  import rv32i_types::*;
#(
  parameter int width    = WIDTH,
  parameter int rob_size = ROB_SIZE,
  parameter int rs_size  = RS_SIZE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      load_alu_rs,
  input  pci_t                      pci,
  input  logic [TAG_W-1:0]          rd_tag,
  input  logic                      src1_rdy,
  input  logic [TAG_W-1:0]          src1_tag,
  input  logic [width-1:0]          src1_data,
  input  logic                      src2_rdy,
  input  logic [TAG_W-1:0]          src2_tag,
  input  logic [width-1:0]          src2_data,
  input  sal_t [rob_size-1:0]       rob_broadcast_bus,
  output logic                      stall_alu,
  output sal_t [rs_size-1:0]        alu_rs_o
);

  rs_entry_t [rs_size-1:0] ent;

  logic [rs_size-1:0] busy_vec, free_vec, ready_vec;
  logic [rs_size-1:0] alloc_oh, issue_oh;
  logic               do_alloc, do_issue;
  logic [rs_size-1:0] s1_hit, s2_hit;
  logic [rs_size-1:0][width-1:0] s1_val, s2_val;
  rs_entry_t          new_ent;
  rs_entry_t          sel;
  sal_t               b1, b2;
  logic [width-1:0]   op_a, op_b, alu_res;
  logic               unused_bits;

  // Look up the bus slot for a tag; tags outside the bus read as not ready.
  function automatic sal_t bus_peek(input logic [TAG_W-1:0] q,
                                    input sal_t [rob_size-1:0] bus);
    sal_t r;
    r = '0;
    for (int k = 0; k < rob_size; k++)
      if (q == TAG_W'(k)) r = bus[k];
    return r;
  endfunction

  // Per-entry status vectors and lowest-index priority picks
  always_comb begin
    busy_vec  = '0;
    ready_vec = '0;
    for (int i = 0; i < rs_size; i++) begin
      busy_vec[i]  = ent[i].busy;
      ready_vec[i] = ent[i].busy & ent[i].r1 & ent[i].r2;
    end
    free_vec = ~busy_vec;
    alloc_oh = free_vec & (~free_vec + rs_size'(1));
    issue_oh = ready_vec & (~ready_vec + rs_size'(1));
  end

  assign stall_alu = &busy_vec;
  assign do_alloc  = load_alu_rs & ~stall_alu;
  assign do_issue  = |ready_vec;

  // Snoop: match every entry's pending source tags against the bus
  always_comb begin
    s1_hit = '0;
    s2_hit = '0;
    s1_val = '0;
    s2_val = '0;
    for (int i = 0; i < rs_size; i++) begin
      for (int k = 0; k < rob_size; k++) begin
        if (ent[i].q1 == TAG_W'(k) && rob_broadcast_bus[k].rdy) begin
          s1_hit[i] = 1'b1;
          s1_val[i] = rob_broadcast_bus[k].data;
        end
        if (ent[i].q2 == TAG_W'(k) && rob_broadcast_bus[k].rdy) begin
          s2_hit[i] = 1'b1;
          s2_val[i] = rob_broadcast_bus[k].data;
        end
      end
    end
  end

  // Build the entry to allocate, including same-cycle bus bypass
  always_comb begin
    b1 = bus_peek(src1_tag, rob_broadcast_bus);
    b2 = bus_peek(src2_tag, rob_broadcast_bus);
    new_ent         = '0;
    new_ent.busy    = 1'b1;
    new_ent.tag     = rd_tag;
    new_ent.op      = decode_op(pci);
    new_ent.use_pc  = (pci.opcode == op_auipc);
    new_ent.use_imm = (pci.opcode == op_imm) || (pci.opcode == op_auipc);
    new_ent.q1      = src1_tag;
    new_ent.q2      = src2_tag;
    new_ent.imm     = pci.imm;
    new_ent.pc      = pci.pc;
    if (new_ent.use_pc)  new_ent.r1 = 1'b1;
    else if (src1_rdy) begin new_ent.r1 = 1'b1; new_ent.v1 = src1_data; end
    else if (b1.rdy)   begin new_ent.r1 = 1'b1; new_ent.v1 = b1.data;   end
    if (new_ent.use_imm) new_ent.r2 = 1'b1;
    else if (src2_rdy) begin new_ent.r2 = 1'b1; new_ent.v2 = src2_data; end
    else if (b2.rdy)   begin new_ent.r2 = 1'b1; new_ent.v2 = b2.data;   end
  end

  // Issue mux: pick the selected entry and form its operands
  always_comb begin
    sel = '0;
    for (int i = 0; i < rs_size; i++)
      if (issue_oh[i]) sel = ent[i];
    op_a = sel.use_pc  ? sel.pc  : sel.v1;
    op_b = sel.use_imm ? sel.imm : sel.v2;
  end

  rs_alu_unit #(.width(width)) u_alu (
    .op     (sel.op),
    .a      (op_a),
    .b      (op_b),
    .result (alu_res)
  );

  // Entry storage: allocate, snoop-capture and free-on-issue
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      ent <= '0;
    end else begin
      for (int i = 0; i < rs_size; i++) begin
        if (do_alloc && alloc_oh[i]) begin
          ent[i] <= new_ent;
        end else begin
          if (ent[i].busy && !ent[i].r1 && s1_hit[i]) begin
            ent[i].r1 <= 1'b1;
            ent[i].v1 <= s1_val[i];
          end
          if (ent[i].busy && !ent[i].r2 && s2_hit[i]) begin
            ent[i].r2 <= 1'b1;
            ent[i].v2 <= s2_val[i];
          end
          if (issue_oh[i]) ent[i].busy <= 1'b0;
        end
      end
    end
  end

  // Completion port: one-cycle pulse on the issuing entry's slot
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      alu_rs_o <= '0;
    end else begin
      for (int i = 0; i < rs_size; i++) begin
        alu_rs_o[i] <= '0;
        if (do_issue && issue_oh[i]) begin
          alu_rs_o[i].tag  <= sel.tag;
          alu_rs_o[i].rdy  <= 1'b1;
          alu_rs_o[i].data <= alu_res;
        end
      end
    end
  end

  // Bus tags are positional and only funct7[5] matters to decode
  always_comb begin
    unused_bits = ^pci.funct7;
    for (int k = 0; k < rob_size; k++)
      unused_bits = unused_bits ^ (^rob_broadcast_bus[k].tag);
  end

endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- Holds decoded ALU-class instructions dispatched by the reorder buffer until their source operands are available, then executes them one per cycle.
- Snoops the ROB broadcast bus to capture operands that are still outstanding.
- Returns each completed result to the ROB as an sal_t in the alu_rs_o array, which is the producer side of the ROB's completion interface.
- Sits between ROB dispatch and ROB completion; pairs with the branch and load/store units.

Parameters:
width, 32, data width
rob_size, 8, ROB entries; depth of the broadcast bus; tag range 0..rob_size-1
rs_size, 8, reservation station entries; depth of alu_rs_o

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-low reset
flush  input  1  synchronous clear of all entries (mispredict); same effect as reset
load_alu_rs  input  1  allocate an entry from pci this cycle
pci  input  pci_t  decoded instruction (opcode, funct3, funct7, imm, pc)
rd_tag  input  4  ROB tag of the instruction being loaded
src1_rdy  input  1  src1_data is valid
src1_tag  input  4  ROB tag producing src1 when not ready
src1_data  input  width  src1 value
src2_rdy  input  1  src2_data is valid
src2_tag  input  4  ROB tag producing src2 when not ready
src2_data  input  width  src2 value
rob_broadcast_bus  input  sal_t [rob_size]  per-tag {tag, rdy, data} from the ROB
stall_alu  output  1  station full; the ROB must not assert load_alu_rs
alu_rs_o  output  sal_t [rs_size]  per-entry completion to the ROB

Behaviour:
- Reset (rst==0) or flush: every entry's busy bit is cleared, alu_rs_o[i] is all zeros, and stall_alu=0.
  - Reset has priority over load, capture and issue. A mid-operation reset discards all entries and any pending output.
- Entry contents: busy, tag, op, q1/q2 tags, r1/r2 ready bits, v1/v2 values, imm, pc.
- Allocation:
  - On load_alu_rs with stall_alu==0, the lowest-index non-busy entry is written at the clock edge.
  - load_alu_rs while stall_alu==1 is ignored; no entry changes.
  - stall_alu is the AND of all registered busy bits. A slot freed by issue this cycle becomes usable next cycle only.
- Load-time bypass: if srcN_rdy==0 and rob_broadcast_bus[srcN_tag].rdy==1 in the same cycle, the entry is written with rN=1 and vN taken from the bus data.
- Snoop: every busy entry with rN==0 captures rob_broadcast_bus[qN].data and sets rN=1 when that bus entry's rdy==1. This applies to all entries in parallel each cycle.
- Operand 2 source by opcode:
  - op_reg uses v2.
  - op_imm uses imm; r2 is forced to 1 at load.
  - op_auipc: operand 1 is pc and operand 2 is imm; r1 and r2 are forced to 1.
- Operations: add, sub (funct7[5] with op_reg), sll, slt, sltu, xor, srl, sra (funct7[5]), or, and.
  - Shifts use operand2[4:0].
  - slt/sltu results are zero-extended to width bits.
  - Arithmetic is modulo 2^width.
- Issue:
  - Each cycle, select the lowest-index entry with busy & r1 & r2.
  - At the next edge: alu_rs_o[idx] <= {tag, 1, result} and busy[idx] <= 0.
  - Latency: operands ready in a registered entry → result visible one cycle later.
  - Operands captured by snoop become eligible for issue the cycle after capture.
- alu_rs_o[i] is a one-cycle pulse: it returns to all zeros the cycle after it was set, unless entry i issues again.
  - At most one alu_rs_o index has rdy=1 per cycle.
- Simultaneous load, snoop and issue in one cycle are all legal. The issuing entry is never the entry being allocated in that cycle.

Decomposition:
- rv32i_types holds:
  - the rs_entry_t typedef;
  - an alu_ops enum;
  - decode helper constants for funct3/funct7.
- One combinational sub-module, rs_alu_unit: inputs op, a, b; output width-bit result.
- Entry storage, snoop logic and the priority selector stay in the top module.

Test Plan:
- Reset then load op_imm addi (src1_rdy=1, src1_data=5, imm=7, rd_tag=3) → two edges later alu_rs_o[0]={3,1,12}; cleared the following cycle.
- Load op_reg add with src2_rdy=0, src2_tag=6; three cycles later rob_broadcast_bus[6]={6,1,100} with src1=1 → capture next edge, alu_rs_o[0]={tag,1,101} one cycle after.
- Fill all 8 entries with unready operands → stall_alu=1; a further load_alu_rs changes nothing; broadcast one tag → after issue stall_alu=0 one cycle later.
- Two entries become ready in the same cycle (entries 2 and 5) → entry 2 issues first, entry 5 the next cycle; sub/sra/sltu with 0xFFFFFFF0 operands give correct results.
- Load with src1_tag=4 while rob_broadcast_bus[4].rdy=1 in the same cycle → the entry captures the bus data and issues without waiting.
- Assert rst=0 or flush while entries are busy and an output is pulsing → all alu_rs_o zero and stall_alu=0 at the next edge; no later completion appears.
